// File: rtl/xswitch_pkg.sv
// xswitch shared definitions.
// Port-count and word-width defaults plus the derived tag types.
package xswitch_pkg;

  localparam int DEF_NPORTS = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_AW     = $clog2(DEF_NPORTS);

  typedef logic [DEF_AW-1:0] port_idx_t;
  typedef logic [DEF_DW-1:0] word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one crossbar output.
// Holds its own priority pointer; advances past each winner.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [AW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [AW-1:0] ptr;
  logic [AW-1:0] idx;

  // N is a power of two, so AW-bit addition wraps mod N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + AW'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= gnt_idx + AW'(1);
    end
  end

endmodule

// File: rtl/xswitch.sv
// Four-port crossbar packet switch with per-output round-robin.
// Granted words land in the output registers one cycle later.
module xswitch
  import xswitch_pkg::*;
#(
  parameter  int NPORTS = DEF_NPORTS,
  parameter  int DW     = DEF_DW,
  localparam int AW     = $clog2(NPORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    in_valid,
  input  logic [NPORTS*AW-1:0] in_addr,
  input  logic [NPORTS*DW-1:0] in_data,
  output logic [NPORTS-1:0]    in_ready,
  output logic [NPORTS-1:0]    out_valid,
  output logic [NPORTS*DW-1:0] out_data,
  output logic [NPORTS*AW-1:0] out_src
);

  logic [NPORTS-1:0] req  [NPORTS];
  logic [NPORTS-1:0] gnt  [NPORTS];
  logic [AW-1:0]     gidx [NPORTS];
  logic [DW-1:0]     din  [NPORTS];
  logic [NPORTS-1:0] gany;

  // req[j][i]: input i wants output j
  always_comb begin
    for (int j = 0; j < NPORTS; j++) begin
      req[j] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[j][i] = in_valid[i] &&
                    (in_addr[i*AW +: AW] == AW'(j));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      din[i] = in_data[i*DW +: DW];
    end
  end

  for (genvar j = 0; j < NPORTS; j++) begin : g_arb
    rr_arbiter #(.N(NPORTS)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req[j]),
      .gnt     (gnt[j]),
      .gnt_idx (gidx[j]),
      .gnt_vld (gany[j])
    );
  end

  // One request per input, so at most one grant column is set.
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < NPORTS; j++) begin
      in_ready = in_ready | gnt[j];
    end
    if (!reset) in_ready = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        out_valid[j] <= gany[j];
        if (gany[j]) begin
          out_data[j*DW +: DW] <= din[gidx[j]];
          out_src[j*AW +: AW]  <= gidx[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_xswitch.sv
// Self-checking bench for xswitch.
// Queue-free scan model plus directed literal checks.
module tb_xswitch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  in_valid;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_src;

  int tests = 0;
  int fails = 0;

  int         mptr [4] = '{default: 0};
  bit         mval [4] = '{default: 1'b0};
  logic [7:0] mdat [4] = '{default: 8'h00};
  int         msrc [4] = '{default: 0};

  xswitch dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  // first requester of output j scanning from its pointer, or -1
  function automatic int win(int j);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (mptr[j] + k) % 4;
      if (in_valid[i] && int'(in_addr[i*2 +: 2]) == j) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    r = '0;
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        int g;
        g = win(j);
        if (g >= 0) r[g] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < 4; j++) begin
        mptr[j] <= 0;
        mval[j] <= 1'b0;
        mdat[j] <= 8'h00;
        msrc[j] <= 0;
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        int g;
        g = win(j);
        if (g >= 0) begin
          mval[j] <= 1'b1;
          mdat[j] <= in_data[g*8 +: 8];
          msrc[j] <= g;
          mptr[j] <= (g + 1) % 4;
        end else begin
          mval[j] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [7:0]  es;
    for (int j = 0; j < 4; j++) begin
      ev[j]        = mval[j];
      ed[j*8 +: 8] = mdat[j];
      es[j*2 +: 2] = 2'(msrc[j]);
    end
    chk("model_ready", 32'(in_ready), 32'(exp_ready()));
    chk("model_valid", 32'(out_valid), 32'(ev));
    chk("model_data", out_data, ed);
    chk("model_src", 32'(out_src), 32'(es));
  end

  initial begin
    int e;
    in_valid = 4'b1111;
    in_addr  = 8'h00;
    in_data  = 32'hC3C2C1C0;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_first_ready", 32'(in_ready), 32'b0001);

    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("cont_valid", 32'(out_valid), 32'b0001);
      chk("cont_src", 32'(out_src[1:0]), 32'(k % 4));
      chk("cont_data", 32'(out_data[7:0]), 32'(8'hC0 + k % 4));
      chk("cont_ready", 32'(in_ready), 32'(1 << ((k + 1) % 4)));
    end

    in_valid = 4'b0100;
    in_addr  = 8'h10;
    in_data  = 32'h00A50000;
    #1;
    chk("single_ready", 32'(in_ready), 32'b0100);
    @(posedge clk);
    #1;
    chk("single_valid", 32'(out_valid), 32'b0010);
    chk("single_data", 32'(out_data[15:8]), 32'hA5);
    chk("single_src", 32'(out_src[3:2]), 32'd2);

    in_valid = 4'b1111;
    in_addr  = 8'h1B;
    in_data  = 32'h13121110;
    #1;
    chk("perm_ready", 32'(in_ready), 32'b1111);
    @(posedge clk);
    #1;
    chk("perm_valid", 32'(out_valid), 32'b1111);
    chk("perm_data", out_data, 32'h10111213);
    chk("perm_src", 32'(out_src), 32'h1B);

    // output 2 pointer sits at 2 after the permutation
    in_valid = 4'b1010;
    in_addr  = 8'h88;
    in_data  = 32'h53005100;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 3 : 1;
      #1;
      chk("fair_ready", 32'(in_ready), 32'(1 << e));
      @(posedge clk);
      #1;
      chk("fair_src", 32'(out_src[5:4]), 32'(e));
      chk("fair_data", 32'(out_data[23:16]),
          (e == 3) ? 32'h53 : 32'h51);
    end

    #1;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_src", 32'(out_src), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_ptr_ready", 32'(in_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk("arst_ptr_src", 32'(out_src[5:4]), 32'd1);

    repeat (40) begin
      in_valid = 4'($urandom);
      in_addr  = 8'($urandom);
      in_data  = $urandom;
      @(posedge clk);
      #1;
    end

    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
